// File: rtl/t02_lcd_num_formatter_if.sv
// Bus between the LCD number formatter and whatever requests screen updates.
`timescale 1ns/1ps
interface t02_lcd_num_formatter_if;
  logic         update;
  logic [31:0]  value_1;
  logic [31:0]  value_2;
  logic [47:0]  label_1;
  logic [47:0]  label_2;
  logic [127:0] row_1;
  logic [127:0] row_2;
  logic         busy;
  logic         done;

  modport master (
    output update, value_1, value_2, label_1, label_2,
    input  row_1, row_2, busy, done
  );

  modport slave (
    input  update, value_1, value_2, label_1, label_2,
    output row_1, row_2, busy, done
  );
endinterface

// File: rtl/t02_lcd_num_formatter.sv
// Converts two 32-bit values to labelled 16-char decimal ASCII rows using an
// iterative double-dabble, then commits both rows together in one cycle.
`timescale 1ns/1ps
module t02_lcd_num_formatter #(
  parameter logic [7:0] PAD_CHAR   = 8'h20,
  parameter bit         ZERO_BLANK = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  t02_lcd_num_formatter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CONV1,
    FMT1,
    CONV2,
    FMT2,
    COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q;
  logic [31:0]   bin_q;
  logic [39:0]   bcd_q;
  logic [31:0]   val2_q;
  logic [47:0]   lab1_q, lab2_q;
  logic [127:0]  stage1_q, stage2_q;
  logic [127:0]  row1_q, row2_q;
  logic          done_q;

  logic [39:0]   bcd_adj;
  logic [79:0]   fmt;
  logic          lead;
  logic [3:0]    dig;

  // Next-state logic of the conversion sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.update) state_d = CONV1;
      CONV1:   if (cnt_q == 6'd31) state_d = FMT1;
      FMT1:    state_d = CONV2;
      CONV2:   if (cnt_q == 6'd31) state_d = FMT2;
      FMT2:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // ASCII rendering of the BCD result, msd first; least significant digit never blanked
  always_comb begin
    fmt  = '0;
    lead = ZERO_BLANK;
    dig  = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      dig = bcd_q[39-4*i -: 4];
      if (lead && (dig == 4'd0) && (i != 9)) begin
        fmt[79-8*i -: 8] = PAD_CHAR;
      end else begin
        fmt[79-8*i -: 8] = 8'h30 + {4'h0, dig};
        lead = 1'b0;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture, conversion datapath, staging and the single-cycle commit of both rows
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      val2_q   <= '0;
      lab1_q   <= '0;
      lab2_q   <= '0;
      stage1_q <= {16{8'h20}};
      stage2_q <= {16{8'h20}};
      row1_q   <= {16{8'h20}};
      row2_q   <= {16{8'h20}};
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.update) begin
            bin_q  <= bus.value_1;
            val2_q <= bus.value_2;
            lab1_q <= bus.label_1;
            lab2_q <= bus.label_2;
            bcd_q  <= '0;
            cnt_q  <= '0;
          end
        end
        CONV1, CONV2: begin
          bcd_q <= {bcd_adj[38:0], bin_q[31]};
          bin_q <= {bin_q[30:0], 1'b0};
          cnt_q <= cnt_q + 6'd1;
        end
        FMT1: begin
          stage1_q <= {lab1_q, fmt};
          bin_q    <= val2_q;
          bcd_q    <= '0;
          cnt_q    <= '0;
        end
        FMT2: begin
          stage2_q <= {lab2_q, fmt};
        end
        COMMIT: begin
          row1_q <= stage1_q;
          row2_q <= stage2_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.row_1 = row1_q;
  assign bus.row_2 = row2_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);

endmodule
